// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
// Covers the FSM state enum, the redirect alignment mask and the RAS pointer width.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Low address bits that must be zero for an instruction-aligned PC.
    function automatic logic [31:0] align_mask(input int unsigned instr_bytes);
        return instr_bytes - 32'd1;
    endfunction

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry.
// Pop together with push replaces the top entry in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = ras_ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   top_idx;
    logic            pop_ok;

    assign top_idx = ptr_q - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push && !pop_ok) begin
            ptr_q <= ptr_q + PW'(1);
            if (cnt_q != CW'(DEPTH))
                cnt_q <= cnt_q + CW'(1);
        end else if (pop_ok && !push) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // NOTE: the entry array has no reset; the occupancy count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!flush && push)
            mem[pop_ok ? top_idx : ptr_q] <= push_data;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with BOOT/RUN/HALT control and misaligned-redirect flag.
// Define PC_RAS_EN to add the return-address stack that predicts return targets.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100),
    parameter int              INSTR_BYTES = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            call_valid,
    input  logic            ret_valid,
    input  logic            pc_ready,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_seq,
    output logic            halted,
    output logic            misaligned
);

`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INSTR_BYTES));
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic            fire;
    logic [XLEN-1:0] redir_aligned;
    logic            redir_mis;
    logic            ras_push, ras_pop, ras_flush, ras_empty;
    logic [XLEN-1:0] ras_top;

    assign pc_valid      = (state_q == RUN);
    assign halted        = (state_q == HALT);
    assign pc            = pc_q;
    assign pc_seq        = pc_q + STEP;
    assign misaligned    = mis_q;
    assign fire          = pc_valid & pc_ready & ~stall;
    assign redir_aligned = redirect_pc & ~ALIGN_MASK;
    assign redir_mis     = |(redirect_pc & ALIGN_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mis_d     = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_flush = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (trap_valid) begin
                    pc_d      = TRAP_VEC;
                    ras_flush = 1'b1;
                    if (halt_req)
                        state_d = HALT;
                end else if (redirect_valid) begin
                    pc_d  = redir_aligned;
                    mis_d = redir_mis;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (fire) begin
                    ras_push = RAS_EN & call_valid;
                    if (RAS_EN && ret_valid && !ras_empty) begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            HALT: begin
                // Trap exits HALT; a redirect only retargets, and resume outranks a repeated halt_req.
                if (trap_valid) begin
                    pc_d      = TRAP_VEC;
                    ras_flush = 1'b1;
                    state_d   = RUN;
                end else begin
                    if (redirect_valid) begin
                        pc_d  = redir_aligned;
                        mis_d = redir_mis;
                    end
                    if (resume)
                        state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (ras_flush),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = ^{call_valid, ret_valid, ras_push, ras_pop, ras_flush};
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a queue-based model.
// The RAS scenario and model path are active when PC_RAS_EN is defined.
module tb_pc_gen;

    localparam int          IB    = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TRAP  = 32'h0000_0100;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, trap_valid, redirect_valid, halt_req, resume;
    logic        call_valid, ret_valid, pc_ready;
    logic [31:0] redirect_pc;
    logic        pc_valid, halted, misaligned;
    logic [31:0] pc, pc_seq;

    logic        rst8, redirect8, ready8;
    logic [7:0]  rpc8;
    logic        valid8, halted8, mis8;
    logic [7:0]  pc8, pc_seq8;

    int checks   = 0;
    int failures = 0;

    typedef enum {M_BOOT, M_RUN, M_HALT} mode_e;
    mode_e       m_mode;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(TRAP), .INSTR_BYTES(IB), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap_valid(trap_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .resume(resume), .call_valid(call_valid),
        .ret_valid(ret_valid), .pc_ready(pc_ready), .pc_valid(pc_valid),
        .pc(pc), .pc_seq(pc_seq), .halted(halted), .misaligned(misaligned)
    );

    pc_gen #(
        .XLEN(8), .RESET_VEC(8'h00), .TRAP_VEC(8'h80), .INSTR_BYTES(4), .RAS_DEPTH(4)
    ) dut8 (
        .clk(clk), .rst(rst8), .stall(1'b0), .trap_valid(1'b0),
        .redirect_valid(redirect8), .redirect_pc(rpc8),
        .halt_req(1'b0), .resume(1'b0), .call_valid(1'b0),
        .ret_valid(1'b0), .pc_ready(ready8), .pc_valid(valid8),
        .pc(pc8), .pc_seq(pc_seq8), .halted(halted8), .misaligned(mis8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_BOOT;
        m_pc   = 32'h0;
        m_mis  = 1'b0;
        m_ras.delete();
    endtask

    task automatic compare_model();
        check("pc", pc, m_pc);
        check("pc_seq", pc_seq, 32'((64'(m_pc) + 64'(IB)) % 64'h1_0000_0000));
        check("pc_valid", 32'(pc_valid), 32'(m_mode == M_RUN));
        check("halted", 32'(halted), 32'(m_mode == M_HALT));
        check("misaligned", 32'(misaligned), 32'(m_mis));
    endtask

    // Advance one clock: predict from the current inputs, then compare after the edge.
    task automatic step();
        mode_e       n_mode = m_mode;
        logic [31:0] n_pc   = m_pc;
        logic        n_mis  = 1'b0;
        logic [31:0] low    = redirect_pc % 32'(IB);
        logic [31:0] seq    = 32'((64'(m_pc) + 64'(IB)) % 64'h1_0000_0000);
        bit          fire   = (m_mode == M_RUN) && pc_ready && !stall;
        case (m_mode)
            M_BOOT: n_mode = M_RUN;
            M_RUN: begin
                if (trap_valid) begin
                    n_pc = TRAP;
                    m_ras.delete();
                    if (halt_req) n_mode = M_HALT;
                end else if (redirect_valid) begin
                    n_pc  = redirect_pc - low;
                    n_mis = (low != 0);
                end else if (halt_req) begin
                    n_mode = M_HALT;
                end else if (fire) begin
                    if (RAS_EN && ret_valid && m_ras.size() > 0) n_pc = m_ras.pop_back();
                    else n_pc = seq;
                    if (RAS_EN && call_valid) begin
                        m_ras.push_back(seq);
                        if (m_ras.size() > DEPTH) m_ras.delete(0);
                    end
                end
            end
            default: begin
                if (trap_valid) begin
                    n_pc = TRAP;
                    m_ras.delete();
                    n_mode = M_RUN;
                end else begin
                    if (redirect_valid) begin
                        n_pc  = redirect_pc - low;
                        n_mis = (low != 0);
                    end
                    if (resume) n_mode = M_RUN;
                end
            end
        endcase
        @(posedge clk);
        #1;
        m_mode = n_mode;
        m_pc   = n_pc;
        m_mis  = n_mis;
        compare_model();
    endtask

    task automatic idle_inputs();
        stall = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        halt_req = 1'b0; resume = 1'b0; call_valid = 1'b0; ret_valid = 1'b0; pc_ready = 1'b1;
    endtask

    task automatic random_inputs();
        stall          = ($urandom_range(0, 99) < 25);
        pc_ready       = ($urandom_range(0, 99) < 80);
        trap_valid     = ($urandom_range(0, 99) < 4);
        redirect_valid = ($urandom_range(0, 99) < 8);
        if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        else redirect_pc = $urandom_range(0, 255);
        halt_req   = ($urandom_range(0, 99) < 5);
        resume     = ($urandom_range(0, 99) < 25);
        call_valid = ($urandom_range(0, 99) < 15);
        ret_valid  = ($urandom_range(0, 99) < 15);
    endtask

    initial begin
        rst = 1'b1; rst8 = 1'b1; redirect8 = 1'b0; rpc8 = 8'h0; ready8 = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 32'h0);
        check("reset_valid", 32'(pc_valid), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_mis", 32'(misaligned), 32'h0);
        rst = 1'b0;

        // T1: one BOOT cycle, then sequential fetch 0,4,8,...
        check("boot_valid", 32'(pc_valid), 32'h0);
        step(); check("t1_pc0", pc, 32'h0); check("t1_valid", 32'(pc_valid), 32'h1);
        step(); check("t1_pc4", pc, 32'h4);
        step(); check("t1_pc8", pc, 32'h8);
        step(); step(); check("t1_pc10", pc, 32'h10);

        // T2: stall holds, redirect acts through stall
        stall = 1'b1;
        repeat (3) step();
        check("t2_stall", pc, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(); check("t2_redir", pc, 32'h40);
        idle_inputs();

        // T3: trap beats misaligned redirect; redirect alone flags misalignment for one cycle
        trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42;
        step(); check("t3_trap_pc", pc, 32'h100); check("t3_trap_mis", 32'(misaligned), 32'h0);
        trap_valid = 1'b0;
        step(); check("t3_mis_pc", pc, 32'h40); check("t3_mis", 32'(misaligned), 32'h1);
        idle_inputs();
        step(); check("t3_mis_drop", 32'(misaligned), 32'h0); check("t3_next", pc, 32'h44);

        // T4: halt at 0x20, resume restarts at the same pc
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step(); idle_inputs();
        halt_req = 1'b1;
        step(); check("t4_halted", 32'(halted), 32'h1); check("t4_valid", 32'(pc_valid), 32'h0);
        check("t4_pc", pc, 32'h20);
        halt_req = 1'b0;
        step(); check("t4_hold", pc, 32'h20);
        resume = 1'b1; halt_req = 1'b1;
        step(); check("t4_resume_valid", 32'(pc_valid), 32'h1); check("t4_resume_pc", pc, 32'h20);
        idle_inputs();
        step(); check("t4_adv", pc, 32'h24);

`ifdef PC_RAS_EN
        // T6: call/return prediction and overflow of the circular stack
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        step(); idle_inputs();
        call_valid = 1'b1;
        step(); call_valid = 1'b0; ret_valid = 1'b1;
        step(); check("t6_ret", pc, 32'h34);
        idle_inputs(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(); idle_inputs(); call_valid = 1'b1;
        repeat (5) step();
        check("t6_calls", pc, 32'h214);
        call_valid = 1'b0; ret_valid = 1'b1;
        step(); check("t6_pop1", pc, 32'h214);
        step(); check("t6_pop2", pc, 32'h210);
        step(); check("t6_pop3", pc, 32'h20C);
        step(); check("t6_pop4", pc, 32'h208);
        step(); check("t6_empty", pc, 32'h20C);
        idle_inputs();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            random_inputs();
            step();
        end

        // Asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_valid", 32'(pc_valid), 32'h0);
        check("async_halted", 32'(halted), 32'h0);
        check("async_mis", 32'(misaligned), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            random_inputs();
            step();
        end

        // T5: 8-bit PC wraps 0xFC -> 0x00 without a flag
        rst8 = 1'b0;
        @(posedge clk); #1;
        check("t5_boot", pc8, 8'h00); check("t5_valid", 32'(valid8), 32'h1);
        redirect8 = 1'b1; rpc8 = 8'hFC;
        @(posedge clk); #1;
        check("t5_fc", pc8, 8'hFC); check("t5_seq", pc_seq8, 8'h00);
        redirect8 = 1'b0;
        @(posedge clk); #1;
        check("t5_wrap", pc8, 8'h00); check("t5_noflag", 32'(mis8), 32'h0);
        check("t5_halted", 32'(halted8), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
